// File: rtl/count_sequencer.sv
// count_sequencer: command-driven front end for an 8-bit up counter with load.
// Takes {start, len, div} over valid/ready, loads the counter with start, then
// issues exactly len increment enables, one every div+1 un-paused cycles.
// Supports pause (freezes the prescaler) and abort (one-cycle counter clear).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready high
// LOAD   | one cycle, cnt_load high with the captured start value
// RUN    | prescaled increment issue until remaining reaches zero
// DONE   | one-cycle done pulse
// CLR    | one-cycle cnt_clr pulse after an abort, no done
module count_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_len,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             pause,
  input  logic             abort,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_data,
  output logic             cnt_enable,
  output logic             cnt_clr,
  output logic             busy,
  output logic [WIDTH-1:0] remaining,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_CLR  = 3'd4
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] len_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pre_q;
  logic [WIDTH-1:0] rem_q;
  logic             load_q;
  logic             clr_q;
  logic             done_q;
  logic             busy_q;
  logic             en_d;

  // Increment enable is the one combinational output: pause and abort must
  // suppress it in the same cycle they are raised.
  always_comb begin
    en_d = 1'b0;
    if (state_q == S_RUN) begin
      en_d = (pre_q == '0) && !pause && !abort;
    end
  end

  // Main sequencer: state, captured command fields, prescaler, remaining
  // count and the registered pulse outputs all advance together here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      start_q <= '0;
      len_q   <= '0;
      div_q   <= '0;
      pre_q   <= '0;
      rem_q   <= '0;
      load_q  <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            start_q <= cmd_start;
            len_q   <= cmd_len;
            div_q   <= cmd_div;
            rem_q   <= cmd_len;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          // abort outranks the zero-length shortcut; pause is ignored here
          if (abort) begin
            rem_q   <= '0;
            clr_q   <= 1'b1;
            state_q <= S_CLR;
          end else if (len_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            pre_q   <= div_q;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            rem_q   <= '0;
            clr_q   <= 1'b1;
            state_q <= S_CLR;
          end else if (en_d) begin
            rem_q <= rem_q - 1'b1;
            pre_q <= div_q;
            if (rem_q == WIDTH'(1)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (!pause) begin
            pre_q <= pre_q - 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_CLR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign cmd_ready  = reset && (state_q == S_IDLE);
  assign cnt_load   = load_q;
  assign cnt_data   = start_q;
  assign cnt_enable = en_d;
  assign cnt_clr    = clr_q;
  assign busy       = busy_q;
  assign remaining  = rem_q;
  assign done       = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer. Expected per-cycle outputs come from a
// timeline model: load in cycle 1, then an increment on every (div+1)-th
// un-paused cycle, done one cycle after the last increment, or a clear one
// cycle after an abort. A downstream counter model tracks the final count.
module tb_count_sequencer;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [W-1:0] cmd_start = '0;
  logic [W-1:0] cmd_len = '0;
  logic [D-1:0] cmd_div = '0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic         cmd_ready, cnt_load, cnt_enable, cnt_clr, busy, done;
  logic [W-1:0] cnt_data, remaining;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(W), .DIV_W(D)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_div(cmd_div),
    .pause(pause), .abort(abort), .cnt_load(cnt_load), .cnt_data(cnt_data),
    .cnt_enable(cnt_enable), .cnt_clr(cnt_clr), .busy(busy),
    .remaining(remaining), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // model timeline, indexed by cycle relative to the acceptance edge
  int m_load[64], m_en[64], m_clr[64], m_done[64], m_busy[64], m_ready[64];
  int m_rem[64], m_data[64], m_pause[64], m_abort[64];
  int m_st, m_len, m_div;
  int mdl_rem = 0;
  int mdl_data = 0;

  logic exp_valid = 1'b0;
  int e_load, e_en, e_clr, e_done, e_busy, e_ready, e_rem, e_data;
  int cyc = 0;

  logic [63:0] en_mask = '0;
  int done_cyc = -1;
  int clr_cyc = -1;
  int load_cnt = 0;
  int obs_rem[64];
  logic [7:0] ctr = '0;
  int last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // per-cycle comparison against the model, plus observation/counter model
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("cnt_load",   32'(cnt_load),   e_load);
      chk("cnt_enable", 32'(cnt_enable), e_en);
      chk("cnt_clr",    32'(cnt_clr),    e_clr);
      chk("done",       32'(done),       e_done);
      chk("busy",       32'(busy),       e_busy);
      chk("cmd_ready",  32'(cmd_ready),  e_ready);
      chk("remaining",  32'(remaining),  e_rem);
      chk("cnt_data",   32'(cnt_data),   e_data);
      if (cnt_enable) en_mask = en_mask | (64'd1 << cyc);
      if (done) done_cyc = cyc;
      if (cnt_clr) clr_cyc = cyc;
      if (cnt_load) load_cnt++;
      obs_rem[cyc] = int'(remaining);
      if (cnt_clr) ctr = '0;
      else if (cnt_load) ctr = cnt_data;
      else if (cnt_enable) ctr = ctr + 8'd1;
    end
  end

  task automatic build(input int st, input int len, input int dv, input int p_lo,
                       input int p_hi, input int ab, output int lst);
    int issued, unp;
    lst = 0;
    for (int c = 0; c < 64; c++) begin
      m_load[c] = 0; m_en[c] = 0; m_clr[c] = 0; m_done[c] = 0;
      m_busy[c] = 0; m_ready[c] = 0; m_rem[c] = 0; m_data[c] = st;
      m_pause[c] = (c >= p_lo && c <= p_hi) ? 1 : 0;
      m_abort[c] = (c == ab) ? 1 : 0;
    end
    m_st = st; m_len = len; m_div = dv;
    m_ready[0] = 1; m_rem[0] = mdl_rem; m_data[0] = mdl_data;
    m_load[1] = 1; m_busy[1] = 1; m_rem[1] = len;
    if (ab == 1) begin
      m_clr[2] = 1; m_busy[2] = 1; lst = 3;
    end else if (len == 0) begin
      m_done[2] = 1; m_busy[2] = 1; lst = 3;
    end else begin
      issued = 0; unp = 0;
      for (int c = 2; c < 60 && lst == 0; c++) begin
        m_busy[c] = 1;
        m_rem[c] = len - issued;
        if (c == ab) begin
          m_clr[c+1] = 1; m_busy[c+1] = 1; lst = c + 2;
        end else if (m_pause[c] == 0) begin
          unp++;
          if (unp % (dv + 1) == 0) begin
            m_en[c] = 1;
            issued++;
            if (issued == len) begin
              m_done[c+1] = 1; m_busy[c+1] = 1; lst = c + 2;
            end
          end
        end
      end
      if (lst == 0) lst = 62;
    end
    m_ready[lst] = 1;
    mdl_data = st;
    mdl_rem = 0;
  endtask

  task automatic drive_cycle(input int c, input bit hold);
    @(posedge clk); #1;
    if (c == 0) begin
      cmd_start = W'(m_st); cmd_len = W'(m_len); cmd_div = D'(m_div);
      en_mask = '0; done_cyc = -1; clr_cyc = -1;
    end
    cmd_valid = (c == 0) || hold;
    pause = (m_pause[c] != 0);
    abort = (m_abort[c] != 0);
    e_load = m_load[c]; e_en = m_en[c]; e_clr = m_clr[c]; e_done = m_done[c];
    e_busy = m_busy[c]; e_ready = m_ready[c]; e_rem = m_rem[c]; e_data = m_data[c];
    cyc = c;
    exp_valid = 1'b1;
  endtask

  task automatic run_cmd(input int st, input int len, input int dv, input int p_lo,
                         input int p_hi, input int ab, input bit hold, output int lst);
    build(st, len, dv, p_lo, p_hi, ab, lst);
    for (int c = 0; c < lst; c++) drive_cycle(c, hold);
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0;
      e_load = 0; e_en = 0; e_clr = 0; e_done = 0; e_busy = 0; e_ready = 1;
      e_rem = mdl_rem; e_data = mdl_data;
      cyc = 63;
      exp_valid = 1'b1;
    end
    @(negedge clk); #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, 32'(cmd_ready), 0);
    chk({nm, "_load"},  32'(cnt_load), 0);
    chk({nm, "_data"},  32'(cnt_data), 0);
    chk({nm, "_en"},    32'(cnt_enable), 0);
    chk({nm, "_clr"},   32'(cnt_clr), 0);
    chk({nm, "_busy"},  32'(busy), 0);
    chk({nm, "_rem"},   32'(remaining), 0);
    chk({nm, "_done"},  32'(done), 0);
  endtask

  initial begin
    int r2[7];
    r2 = '{3, 3, 2, 2, 1, 1, 0};

    #1;
    chk_all_zero("por");
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    idle(2);

    // 1: basic
    run_cmd(8'h10, 3, 0, -1, -1, -1, 1'b0, last);
    chk("t1_last", 32'(last), 6);
    chk("t1_en_cycles", en_mask[31:0], 32'h1C);
    chk("t1_done_cyc", 32'(done_cyc), 5);
    chk("t1_ctr", 32'(ctr), 32'h13);
    idle(1);

    // 2: prescale
    run_cmd(8'h00, 3, 1, -1, -1, -1, 1'b0, last);
    chk("t2_en_cycles", en_mask[31:0], 32'hA8);
    chk("t2_done_cyc", 32'(done_cyc), 8);
    for (int i = 0; i < 7; i++) chk("t2_rem_seq", 32'(obs_rem[i+2]), 32'(r2[i]));
    chk("t2_ctr", 32'(ctr), 32'h03);
    idle(1);

    // 3a: zero length, abort raised in IDLE together with the command
    run_cmd(8'h55, 0, 5, -1, -1, 0, 1'b0, last);
    chk("t3a_en_cycles", en_mask[31:0], 32'h0);
    chk("t3a_done_cyc", 32'(done_cyc), 2);
    chk("t3a_ctr", 32'(ctr), 32'h55);
    // 3b: wrap through FF
    run_cmd(8'hFE, 4, 0, -1, -1, -1, 1'b0, last);
    chk("t3b_en_cycles", en_mask[31:0], 32'h3C);
    chk("t3b_done_cyc", 32'(done_cyc), 6);
    chk("t3b_ctr", 32'(ctr), 32'h02);
    idle(1);

    // 4: pause cycles 2-4, abort in DONE ignored
    run_cmd(8'h20, 2, 0, 2, 4, 7, 1'b0, last);
    chk("t4_en_cycles", en_mask[31:0], 32'h60);
    chk("t4_done_cyc", 32'(done_cyc), 7);
    for (int i = 2; i <= 4; i++) chk("t4_rem_hold", 32'(obs_rem[i]), 2);
    idle(1);

    // 5: abort in RUN
    run_cmd(8'h30, 5, 0, -1, -1, 3, 1'b0, last);
    chk("t5_en_cycles", en_mask[31:0], 32'h04);
    chk("t5_clr_cyc", 32'(clr_cyc), 4);
    chk("t5_done_cyc", 32'(done_cyc), 32'hFFFFFFFF);
    chk("t5_ctr", 32'(ctr), 32'h00);
    idle(1);
    // 5b: abort in LOAD beats the zero-length shortcut
    run_cmd(8'h31, 0, 0, -1, -1, 1, 1'b0, last);
    chk("t5b_clr_cyc", 32'(clr_cyc), 2);
    chk("t5b_done_cyc", 32'(done_cyc), 32'hFFFFFFFF);
    idle(1);

    // 6: asynchronous reset mid-RUN
    build(8'h40, 10, 2, -1, -1, -1, last);
    for (int c = 0; c <= 4; c++) drive_cycle(c, 1'b0);
    @(negedge clk); #1;
    exp_valid = 1'b0;
    #1 reset = 1'b0;
    #1 chk_all_zero("rst_async");
    repeat (2) @(posedge clk);
    #1 chk_all_zero("rst_held");
    @(negedge clk); reset = 1'b1;
    mdl_rem = 0; mdl_data = 0;
    idle(2);

    // 6b: back-to-back with cmd_valid held through the first command
    load_cnt = 0;
    run_cmd(8'hA0, 2, 1, -1, -1, -1, 1'b1, last);
    run_cmd(8'hB0, 1, 0, -1, -1, -1, 1'b0, last);
    chk("t6_loads", 32'(load_cnt), 2);
    chk("t6_ctr", 32'(ctr), 32'hB1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
